// File: rtl/pushbutton_conditioner.sv
// Purpose : per-player pushbutton front end; 2-flop sync, debounce, press and long-press pulse generation.
// Latency : level and press pulse rise DEBOUNCE_MS+2 edges after the first high sample; long pulse LONGPRESS_MS edges later.
// Backpres: none; free-running 1 kHz pipeline, pulses are single-cycle and must be consumed on arrival.
//
// Ports:
//   clk_1khz_i     1 kHz clock, all state updates on its rising edge
//   rst_i          synchronous active-high reset, clears every register
//   pushbutton_i   raw asynchronous button input, active high
//   btn_level_o    debounced button level
//   press_pulse_o  one-cycle pulse per debounced press (plus auto-repeats when enabled)
//   long_press_o   one-cycle pulse once the press has been held LONGPRESS_MS cycles
//
// Build option: define BTN_AUTOREPEAT_EN to emit a press_pulse_o every REPEAT_MS
// cycles after a long press while the button stays held. Without it REPEAT_MS is unused.

module pushbutton_conditioner #(
    parameter int DEBOUNCE_MS  = 4,
    parameter int LONGPRESS_MS = 1000,
    parameter int REPEAT_MS    = 200
) (
    input  logic clk_1khz_i,
    input  logic rst_i,
    input  logic pushbutton_i,
    output logic btn_level_o,
    output logic press_pulse_o,
    output logic long_press_o
);

    localparam int DB_W   = (DEBOUNCE_MS  > 1) ? $clog2(DEBOUNCE_MS + 1)  : 1;
    localparam int HOLD_W = (LONGPRESS_MS > 1) ? $clog2(LONGPRESS_MS + 1) : 1;

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_MS - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONGPRESS_MS);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONGPRESS_MS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HELD = 2'd1,
        LONG = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Synchroniser and debouncer
    // ------------------------------------------------------------------
    logic            s1;
    logic            s2;
    logic [DB_W-1:0] db_cnt;
    logic            level;
    logic            db_done;
    logic            level_rise;
    logic            level_fall;

    // The DEBOUNCE_MS-th consecutive disagreeing sample flips the level in
    // the same edge, so the FSM sees the flip as a combinational event.
    assign db_done    = (s2 != level) && (db_cnt == DB_LAST);
    assign level_rise = db_done && !level;
    assign level_fall = db_done &&  level;

    always_ff @(posedge clk_1khz_i) begin
        if (rst_i) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            db_cnt <= '0;
            level  <= 1'b0;
        end else begin
            s1 <= pushbutton_i;
            s2 <= s1;
            if (s2 == level) begin
                db_cnt <= '0;
            end else if (db_done) begin
                db_cnt <= '0;
                level  <= ~level;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Press / long-press FSM
    // ------------------------------------------------------------------
    state_t            state_q;
    state_t            state_d;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_d;
    logic              press_q;
    logic              press_d;
    logic              long_q;
    logic              long_d;

`ifdef BTN_AUTOREPEAT_EN
    localparam int REP_W = (REPEAT_MS > 1) ? $clog2(REPEAT_MS + 1) : 1;
    localparam logic [REP_W-1:0] REP_MAX = REP_W'(REPEAT_MS);

    logic [REP_W-1:0] rep_cnt;
    logic [REP_W-1:0] rep_d;
`endif

    always_comb begin
        state_d = state_q;
        hold_d  = hold_cnt;
        press_d = 1'b0;
        long_d  = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
        rep_d   = rep_cnt;
`endif
        case (state_q)
            IDLE: begin
                if (level_rise) begin
                    state_d = HELD;
                    hold_d  = '0;
                    press_d = 1'b1;
                end
            end
            HELD: begin
                if (level_fall) begin
                    // Release wins over a long press due in the same cycle.
                    state_d = IDLE;
                    hold_d  = '0;
                end else begin
                    hold_d = hold_cnt + 1'b1;
                    if (hold_cnt == HOLD_LAST) begin
                        long_d  = 1'b1;
                        state_d = LONG;
                    end
                end
            end
            LONG: begin
                if (level_fall) begin
                    state_d = IDLE;
                    hold_d  = '0;
`ifdef BTN_AUTOREPEAT_EN
                    rep_d   = '0;
`endif
                end else begin
                    // Saturate so the counter never wraps on very long holds.
                    if (hold_cnt != HOLD_MAX) begin
                        hold_d = hold_cnt + 1'b1;
                    end
`ifdef BTN_AUTOREPEAT_EN
                    // rep_cnt cycles 1..REPEAT_MS; each arrival at REPEAT_MS repeats the press.
                    rep_d = (rep_cnt == REP_MAX) ? REP_W'(1) : rep_cnt + 1'b1;
                    if (rep_d == REP_MAX) begin
                        press_d = 1'b1;
                    end
`endif
                end
            end
            default: begin
                state_d = IDLE;
                hold_d  = '0;
`ifdef BTN_AUTOREPEAT_EN
                rep_d   = '0;
`endif
            end
        endcase
    end

    always_ff @(posedge clk_1khz_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            hold_cnt <= '0;
            press_q  <= 1'b0;
            long_q   <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
            rep_cnt  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            hold_cnt <= hold_d;
            press_q  <= press_d;
            long_q   <= long_d;
`ifdef BTN_AUTOREPEAT_EN
            rep_cnt  <= rep_d;
`endif
        end
    end

    assign btn_level_o   = level;
    assign press_pulse_o = press_q;
    assign long_press_o  = long_q;

endmodule

// File: tb/tb_pushbutton_conditioner.sv
// Purpose : directed self-checking bench for pushbutton_conditioner (DEBOUNCE_MS=4, LONGPRESS_MS=10, REPEAT_MS=3).
// Latency : outputs sampled 1 time unit after each rising edge; edge numbers are relative to the first stimulus edge of each test.
// Backpres: n/a; stimulus is a fixed linear sequence, expected values are hand-derived per edge.

module tb_pushbutton_conditioner;

`ifdef BTN_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic pb;
    logic level;
    logic press;
    logic lng;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    pushbutton_conditioner #(
        .DEBOUNCE_MS (4),
        .LONGPRESS_MS(10),
        .REPEAT_MS   (3)
    ) dut (
        .clk_1khz_i   (clk),
        .rst_i        (rst),
        .pushbutton_i (pb),
        .btn_level_o  (level),
        .press_pulse_o(press),
        .long_press_o (lng)
    );

    task automatic check1(input string tag, input int e, input logic got, input logic exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s edge %0d: got %b expected %b", tag, e, got, exp);
    endtask

    // Drive inputs, advance one edge, then check all three outputs.
    task automatic tick(input logic r, input logic b, input logic el, input logic ep,
                        input logic elg, input string tag, input int e);
        rst = r;
        pb  = b;
        @(posedge clk);
        #1;
        check1({tag, ".level"}, e, level, el);
        check1({tag, ".press"}, e, press, ep);
        check1({tag, ".long"},  e, lng,   elg);
    endtask

    task automatic do_reset(input string tag);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, tag, -2);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, tag, -1);
    endtask

    initial begin
        rst = 1'b1;
        pb  = 1'b0;

        // Test 1: reset held 3 edges with the button pressed, then re-debounce.
        for (int e = 1; e <= 3; e++) tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "t1_rst", e);
        for (int e = 1; e <= 8; e++)
            tick(1'b0, 1'b1, (e >= 6), (e == 6), 1'b0, "t1", e);
        do_reset("t1_clr");

        // Test 2: 8-cycle press; level 6..13, falls at 14 (first low sample edge 9).
        for (int e = 1; e <= 20; e++)
            tick(1'b0, (e <= 8), (e >= 6 && e <= 13), (e == 6), 1'b0, "t2", e);
        do_reset("t2_clr");

        // Test 3: bouncy 1,1,1,0 x5 then steady 0; nothing may come out.
        for (int e = 0; e < 30; e++)
            tick(1'b0, (e < 20) && (e % 4 != 3), 1'b0, 1'b0, 1'b0, "t3", e + 1);
        do_reset("t3_clr");

        // Test 4: 30-cycle hold; long at 16, level falls at 36.
        for (int e = 1; e <= 40; e++)
            tick(1'b0, (e <= 30), (e >= 6 && e <= 35),
                 (e == 6) || (AR && e >= 19 && e <= 34 && ((e - 19) % 3 == 0)),
                 (e == 16), "t4", e);
        do_reset("t4_clr");

        // Test 5: held button, 1-edge reset at edge 12; re-press at 18, long at 28.
        for (int e = 1; e <= 40; e++)
            tick((e == 12), 1'b1, (e >= 6 && e <= 11) || (e >= 18),
                 (e == 6) || (e == 18) || (AR && e >= 31 && ((e - 31) % 3 == 0)),
                 (e == 28), "t5", e);
        for (int e = 41; e <= 50; e++)
            tick(1'b0, 1'b0, (e <= 45), (AR && e == 43), 1'b0, "t5_rel", e);
        do_reset("t5_clr");

        // Test 6: two 6-sample presses separated by 6 low samples.
        for (int e = 1; e <= 30; e++)
            tick(1'b0, (e <= 6) || (e >= 13 && e <= 18),
                 (e >= 6 && e <= 11) || (e >= 18 && e <= 23),
                 (e == 6) || (e == 18), 1'b0, "t6", e);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
